// File: rtl/hex_overlay_if.sv
// Write-side bus for hex_overlay: register-file writes, bank-swap commit and
// swap status. The master is the host writing values; the slave is the overlay.
interface hex_overlay_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_row;
  logic [1:0]  wr_slot;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic        swap_pending;

  modport master (
    output wr_valid,
    output wr_row,
    output wr_slot,
    output wr_data,
    output wr_commit,
    input  wr_ready,
    input  swap_pending
  );

  modport slave (
    input  wr_valid,
    input  wr_row,
    input  wr_slot,
    input  wr_data,
    input  wr_commit,
    output wr_ready,
    output swap_pending
  );
endinterface

// File: rtl/hex_overlay.sv
// hex_overlay: 32x16 character text window showing 16 rows x 4 slots of 32-bit
// values as hex digits. Two-stage pixel pipeline aligned with blank/vsync.
// Optional double buffering with vsync-synchronised bank swap is enabled by
// defining HEX_OVERLAY_DBUF_EN; the default build is single-banked.
module hex_overlay #(
  parameter int unsigned BASE_X = 0,
  parameter int unsigned BASE_Y = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          blank,
  input  logic          vsync,
  input  logic [7:0]    char_x,
  input  logic [7:0]    char_y,
  input  logic [15:0]   char_data,
  output logic          pixel,
  output logic          blank_o,
  output logic          vsync_o,
  hex_overlay_if.slave  wr
);

`ifdef HEX_OVERLAY_DBUF_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif
  localparam int unsigned NumWords = NumBanks * 64;
  localparam int unsigned AddrW    = $clog2(NumWords);

  logic [31:0]      mem_q [NumWords];
  logic [AddrW-1:0] rd_addr;
  logic [AddrW-1:0] wr_addr;
  logic [31:0]      rd_word;
  logic [8:0]       dx_full;
  logic [8:0]       dy_full;
  logic             hit_d;
  logic [3:0]       nib_d;
  logic             ready_q;
  logic             wr_xfer;

  logic             hit_q, blank_q, vsync_q;
  logic [3:0]       nib_q;
  logic             pixel_q, blank_o_q, vsync_o_q;

  // 9-bit subtraction: bit 8 is the borrow, so positions left/above the window never hit
  assign dx_full = {1'b0, char_x} - 9'(BASE_X);
  assign dy_full = {1'b0, char_y} - 9'(BASE_Y);
  assign hit_d   = !dx_full[8] && (dx_full[7:5] == 3'b000) &&
                   !dy_full[8] && (dy_full[7:4] == 4'b0000);

`ifdef HEX_OVERLAY_DBUF_EN
  logic disp_bank_q, disp_bank_d;
  logic pend_q, pend_d;
  logic vsync_prev_q;
  logic commit_acc;

  assign rd_addr    = {disp_bank_q, dy_full[3:0], dx_full[4:3]};
  assign wr_addr    = {~disp_bank_q, wr.wr_row, wr.wr_slot};
  assign wr.wr_ready = ready_q && !pend_q;
  assign wr.swap_pending = pend_q;
  // A commit counts only alongside a transfer or with no write offered
  assign commit_acc = wr.wr_commit && (wr_xfer || !wr.wr_valid) && !pend_q;

  // Swap on vsync rising edge takes priority; otherwise an accepted commit arms the swap
  always_comb begin
    pend_d      = pend_q;
    disp_bank_d = disp_bank_q;
    if (vsync && !vsync_prev_q && pend_q) begin
      disp_bank_d = ~disp_bank_q;
      pend_d      = 1'b0;
    end else if (commit_acc) begin
      pend_d = 1'b1;
    end
  end

  // Bank select, swap request and vsync edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_bank_q  <= 1'b0;
      pend_q       <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      disp_bank_q  <= disp_bank_d;
      pend_q       <= pend_d;
      vsync_prev_q <= vsync;
    end
  end
`else
  logic unused_commit;

  assign rd_addr         = {dy_full[3:0], dx_full[4:3]};
  assign wr_addr         = {wr.wr_row, wr.wr_slot};
  assign wr.wr_ready     = ready_q;
  assign wr.swap_pending = 1'b0;
  assign unused_commit   = wr.wr_commit;
`endif

  assign wr_xfer = wr.wr_valid && wr.wr_ready;
  assign rd_word = mem_q[rd_addr];
  // Digit 0 is the most significant nibble: shift right by 4*(7-digit)
  assign nib_d   = 4'(rd_word >> {~dx_full[2:0], 2'b00});

  // Value store; the display read above sees the old word in a write cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_xfer) begin
      mem_q[wr_addr] <= wr.wr_data;
    end
  end

  // Write-ready comes up one clock after reset is released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Stage 1 registers the digit lookup; stage 2 indexes the glyph returned by the font engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q     <= 1'b0;
      nib_q     <= 4'h0;
      blank_q   <= 1'b0;
      vsync_q   <= 1'b0;
      pixel_q   <= 1'b0;
      blank_o_q <= 1'b0;
      vsync_o_q <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      nib_q     <= nib_d;
      blank_q   <= blank;
      vsync_q   <= vsync;
      pixel_q   <= hit_q && !blank_q && char_data[nib_q];
      blank_o_q <= blank_q;
      vsync_o_q <= vsync_q;
    end
  end

  assign pixel   = pixel_q;
  assign blank_o = blank_o_q;
  assign vsync_o = vsync_o_q;

endmodule

// File: doc/hex_overlay.md
HEX_OVERLAY -- requirements
Module: hex_overlay

Interface
REQ-001 SHALL have parameter BASE_X, default 0: char column of the left edge of the text window.
REQ-002 SHALL have parameter BASE_Y, default 0: char row of the top edge of the text window.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port blank  input  1  video blanking, same cycle as char_x/char_y.
REQ-006 SHALL have port vsync  input  1  vertical sync, same cycle as char_x/char_y.
REQ-007 SHALL have port char_x  input  8  font-engine character column.
REQ-008 SHALL have port char_y  input  8  font-engine character row.
REQ-009 SHALL have port char_data  input  16  glyph pixel per hex digit 0..F, valid one cycle after char_x/char_y.
REQ-010 SHALL have port wr_valid  input  1  write request.
REQ-011 SHALL have port wr_ready  output  1  write accept; transfer when wr_valid && wr_ready.
REQ-012 SHALL have port wr_row  input  4  text row 0..15.
REQ-013 SHALL have port wr_slot  input  2  32-bit slot within row, 0..3.
REQ-014 SHALL have port wr_data  input  32  value shown as 8 hex digits, MS nibble leftmost.
REQ-015 SHALL have port wr_commit  input  1  request bank swap, sampled on transfer or when wr_valid low.
REQ-016 SHALL have port pixel  output  1  overlay pixel, registered.
REQ-017 SHALL have port blank_o  output  1  blank delayed to align with pixel.
REQ-018 SHALL have port vsync_o  output  1  vsync delayed to align with pixel.
REQ-019 SHALL have port swap_pending  output  1  commit accepted, swap not yet done.

Function
REQ-020 SHALL store 16 rows x 4 slots x 32 bits per bank in flops.
REQ-021 SHALL define window hit: char_x-BASE_X in 0..31 and char_y-BASE_Y in 0..15, unsigned 8-bit subtraction with no wrap-around hit.
REQ-022 SHALL, on hit, select slot = dx[4:3], digit = dx[2:0], nibble = data[31-4*digit -: 4], row = dy[3:0].
REQ-023 SHALL register nibble and hit in stage 1 (cycle t+1); stage 2 SHALL output pixel = hit_d1 && !blank_d1 && char_data[nibble_d1] at t+2.
REQ-024 SHALL drive pixel 0 whenever not hit or blank, with total latency 2 cycles from char_x/char_y.
REQ-025 SHALL delay blank and vsync by exactly 2 cycles to blank_o/vsync_o.
REQ-026 SHALL write wr_data into the write bank at [wr_row][wr_slot] in the transfer cycle, visible to display read next cycle when single-banked.
REQ-027 SHALL use same-cycle read-before-write: display read in the write cycle returns old data.

Reset
REQ-028 SHALL, while reset_n low, clear all banks, pipeline, pixel, blank_o, vsync_o, swap_pending to 0, and bank select to 0.
REQ-029 SHALL drive wr_ready 0 during reset and 1 in the first cycle after reset_n rises (synchronous deassertion of internal state).
REQ-030 SHALL abandon any pending swap on reset mid-frame.

Configuration
REQ-031 SHALL support macro HEX_OVERLAY_DBUF_EN.
REQ-032 Without HEX_OVERLAY_DBUF_EN: single bank, wr_ready constant 1 after reset, wr_commit ignored, swap_pending constant 0.
REQ-033 With HEX_OVERLAY_DBUF_EN: two banks; writes go to the non-displayed bank; commit sets swap_pending.
REQ-034 With HEX_OVERLAY_DBUF_EN: wr_ready SHALL be 0 while swap_pending is 1; a commit while pending is ignored.
REQ-035 With HEX_OVERLAY_DBUF_EN: on vsync rising edge with swap_pending, toggle display bank and clear swap_pending in the same cycle; the new bank is displayed from the next cycle.
REQ-036 With HEX_OVERLAY_DBUF_EN: wr_commit together with a transfer SHALL write first, then set pending.

Verification
REQ-037 Write row 0 slot 0 = 0x0123_4567; scan char_y=0, char_x=0..7 -> pixel stream matches char_data of digits 0..7 at t+2.
REQ-038 char_x=32 or char_y=16 with char_data all ones -> pixel 0; blank=1 at hit -> pixel 0.
REQ-039 BASE_X=4: char_x=3 -> pixel 0; char_x=4 -> digit 0 of slot 0 shown.
REQ-040 DBUF_EN: write 0xFFFF_FFFF with commit -> display unchanged, wr_ready 0 until vsync rises, then 'F' glyph shown and wr_ready 1.
REQ-041 DBUF_EN: assert reset_n low while swap_pending -> swap_pending 0, bank 0, all pixels show digit '0' glyph on hit.
REQ-042 Write to row 5 slot 2 in the same cycle its digit is displayed -> old value on that pixel, new value next frame.
